// File: rtl/boot_copy_ctr_pkg.sv
// Shared system defines for the boot copy controller: FSM encodings and word geometry.
package boot_copy_ctr_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COPY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/boot_copy_fifo.sv
// Two-entry word buffer between the ROM read port and the SRAM write request.
module boot_copy_fifo
    import boot_copy_ctr_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
endmodule

// File: rtl/boot_copy_ctr.sv
// Boot copy controller: streams len words from boot ROM into SRAM at DST_BASE,
// holding the CPU in reset until the first copy completes.
module boot_copy_ctr
    import boot_copy_ctr_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ROM_ADDR_W  = 10,
    parameter int          SRAM_ADDR_W = 15,
    parameter int unsigned DST_BASE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROM_ADDR_W:0]    len,
    output logic                   busy,
    output logic                   done,
    output logic                   cpu_reset,
    output logic                   rom_en,
    output logic [ROM_ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]      rom_rdata,
    output logic                   sram_valid,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic [DATA_W/8-1:0]    sram_wstrb,
    input  logic                   sram_ready
);
    localparam int CNT_W = ROM_ADDR_W + 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_cnt;
    logic             rd_vld;
    logic             cpu_rst_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic             hs;
    logic             last_hs;
    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic             can_issue;

    assign hs      = sram_valid && sram_ready;
    assign last_hs = hs && (wr_cnt == len_q - CNT_W'(1));

    // Slots still held after this edge, counting the word already in flight;
    // a new read may only go out if one slot is guaranteed free on return.
    assign occ       = {fifo_full, !fifo_full && !fifo_empty};
    assign occ_nxt   = occ + 2'(rd_vld) - 2'(hs);
    assign can_issue = (occ_nxt < 2'd2);

    // The first read is launched in the accepting cycle so data lands two cycles after start.
    always_comb begin
        rom_en = 1'b0;
        if (rst) begin
            if (state == ST_IDLE)
                rom_en = start && (len != '0);
            else if (state == ST_COPY)
                rom_en = (rd_ptr < len_q) && can_issue;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (len == '0) ? ST_DONE : ST_COPY;
            ST_COPY: if (last_hs) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            rd_ptr    <= '0;
            wr_cnt    <= '0;
            rd_vld    <= 1'b0;
            cpu_rst_q <= 1'b1;
            sram_addr <= '0;
        end else begin
            state  <= state_nxt;
            rd_vld <= rom_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        rd_ptr    <= CNT_W'(rom_en);
                        wr_cnt    <= '0;
                        sram_addr <= SRAM_ADDR_W'(DST_BASE);
                    end
                end
                ST_COPY: begin
                    if (rom_en)
                        rd_ptr <= rd_ptr + CNT_W'(1);
                    if (hs) begin
                        wr_cnt    <= wr_cnt + CNT_W'(1);
                        sram_addr <= sram_addr + SRAM_ADDR_W'(WORD_BYTES);
                    end
                end
                default: rd_ptr <= '0;
            endcase
            if (state_nxt == ST_DONE)
                cpu_rst_q <= 1'b0;
        end
    end

    boot_copy_fifo #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_vld),
        .pop   (hs),
        .wdata (rom_rdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rom_addr   = rd_ptr[ROM_ADDR_W-1:0];
    assign sram_valid = !fifo_empty;
    assign sram_wdata = fifo_rdata;
    assign sram_wstrb = {(DATA_W/8){sram_valid}};
    assign busy       = (state == ST_COPY);
    assign done       = (state == ST_DONE);
    assign cpu_reset  = cpu_rst_q;
endmodule

// File: tb/tb_boot_copy_ctr.sv
// Scoreboard bench for boot_copy_ctr: default instance plus a wrap-around DST_BASE instance.
module tb_boot_copy_ctr;
    typedef struct packed {
        logic [14:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start, start_b;
    logic [10:0] len, len_b;
    logic        busy, done, cpu_reset, rom_en, sram_valid, sram_ready;
    logic        busy_b, done_b, cpu_reset_b, rom_en_b, sram_valid_b;
    logic [9:0]  rom_addr, rom_addr_b;
    logic [31:0] rom_rdata, rom_rdata_b, sram_wdata, sram_wdata_b;
    logic [14:0] sram_addr, sram_addr_b;
    logic [3:0]  sram_wstrb, sram_wstrb_b;
    logic [31:0] rom_base;
    logic [10:0] exp_len;

    exp_t exp_q[$];
    exp_t exp_qb[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   rom_cnt  = 0;

    boot_copy_ctr dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .cpu_reset(cpu_reset), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wstrb(sram_wstrb), .sram_ready(sram_ready)
    );

    boot_copy_ctr #(.DST_BASE(32'h7FF8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .len(len_b), .busy(busy_b), .done(done_b),
        .cpu_reset(cpu_reset_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b),
        .sram_valid(sram_valid_b), .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b),
        .sram_wstrb(sram_wstrb_b), .sram_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Boot ROM model: one-cycle read latency, word i holds rom_base + i.
    always @(posedge clk) begin
        if (rom_en)   rom_rdata   <= rom_base + 32'(rom_addr);
        if (rom_en_b) rom_rdata_b <= rom_base + 32'(rom_addr_b);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && sram_valid && sram_ready) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got addr %h data %h, required no write", sram_addr, sram_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({sram_addr, sram_wdata} !== {e.addr, e.data})
                    $display("FAIL sb_write: got %h/%h required %h/%h", sram_addr, sram_wdata, e.addr, e.data);
                else pass_cnt++;
            end
            chk_cnt++;
            if (sram_wstrb !== 4'hF) $display("FAIL wstrb: got %h required f", sram_wstrb);
            else pass_cnt++;
        end
        if (rst && rom_en) begin
            rom_cnt++;
            chk_cnt++;
            if ({1'b0, rom_addr} >= exp_len)
                $display("FAIL rom_addr_range: got %h required below %h", rom_addr, exp_len);
            else pass_cnt++;
        end
        if (rst && sram_valid_b) begin
            chk_cnt++;
            if (exp_qb.size() == 0) begin
                $display("FAIL sb_b_unexpected_write: got addr %h, required no write", sram_addr_b);
            end else begin
                e = exp_qb.pop_front();
                if ({sram_addr_b, sram_wdata_b} !== {e.addr, e.data})
                    $display("FAIL sb_b_write: got %h/%h required %h/%h", sram_addr_b, sram_wdata_b, e.addr, e.data);
                else pass_cnt++;
            end
        end
    end

    task automatic push_exp(input int n, input logic [14:0] base, input bit to_b);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + 15'(4 * i);
            e.data = rom_base + 32'(i);
            if (to_b) exp_qb.push_back(e);
            else      exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; len = 11'd5; start_b = 1'b0; len_b = '0;
        sram_ready = 1'b1; exp_len = '0; rom_base = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, rom_en, sram_valid, sram_wstrb} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000", {busy, done, rom_en, sram_valid, sram_wstrb});
        else pass_cnt++;
        chk_cnt++;
        if ({rom_addr, sram_addr, sram_wdata} !== '0)
            $display("FAIL reset_data: got %h/%h/%h required 0/0/0", rom_addr, sram_addr, sram_wdata);
        else pass_cnt++;
        chk_cnt++;
        if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b required 1", cpu_reset);
        else pass_cnt++;
        start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, rom_en, cpu_reset} !== 4'b0001)
            $display("FAIL idle_wait: got %b required 0001", {busy, done, rom_en, cpu_reset});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int first_v = -1, first_d = -1, rd;
        rom_base = 32'hA0; exp_len = 11'd4;
        push_exp(4, 15'h0, 1'b0);
        rd = rom_cnt;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            start = (k == 0); len = 11'd4;
            @(negedge clk);
            if (sram_valid && first_v < 0) first_v = k;
            if (done && first_d < 0) first_d = k;
            if (k == 3) begin
                chk_cnt++;
                if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy);
                else pass_cnt++;
            end
            if (k == 5) begin
                chk_cnt++;
                if (cpu_reset !== 1'b1) $display("FAIL basic_cpu_reset_before: got %b required 1", cpu_reset);
                else pass_cnt++;
            end
            if (k == 6) begin
                chk_cnt++;
                if ({done, busy, cpu_reset} !== 3'b100)
                    $display("FAIL basic_done_cycle: got %b required 100", {done, busy, cpu_reset});
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (first_v !== 2) $display("FAIL basic_first_valid: got %0d required 2", first_v);
        else pass_cnt++;
        chk_cnt++;
        if (first_d !== 6) $display("FAIL basic_done_latency: got %0d required 6", first_d);
        else pass_cnt++;
        chk_cnt++;
        if (rom_cnt - rd !== 4) $display("FAIL basic_rom_reads: got %0d required 4", rom_cnt - rd);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL basic_left: got %0d required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        int hs = 0, dn = 0;
        rom_base = 32'h1234_0000; exp_len = 11'd8;
        push_exp(8, 15'h0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) begin
            start = (k == 0) || (k == 3) || (k == 10);
            len   = (k == 0) ? 11'd8 : 11'd2;
            @(negedge clk);
            if (sram_valid && sram_ready) hs++;
            if (done) dn++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk_cnt++;
        if (hs !== 8) $display("FAIL restart_words: got %0d required 8", hs);
        else pass_cnt++;
        chk_cnt++;
        if (dn !== 1) $display("FAIL restart_done_pulses: got %0d required 1", dn);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL restart_left: got %0d required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int hold = 0, first_d = -1, rd;
        bit stable = 1'b1, cpu_hi = 1'b0;
        logic [31:0] held = '0;
        rom_base = 32'hC000_0000; exp_len = 11'd3;
        push_exp(3, 15'h0, 1'b0);
        rd = rom_cnt;
        @(posedge clk); #1;
        for (int k = 0; k < 14; k++) begin
            start = (k == 0); len = 11'd3;
            sram_ready = !(k >= 3 && k <= 7);
            @(negedge clk);
            if (sram_valid && sram_addr == 15'h4) begin
                hold++;
                if (hold == 1) held = sram_wdata;
                else if (sram_wdata !== held) stable = 1'b0;
            end
            if (cpu_reset) cpu_hi = 1'b1;
            if (done && first_d < 0) first_d = k;
            @(posedge clk); #1;
        end
        sram_ready = 1'b1;
        chk_cnt++;
        if (hold !== 6) $display("FAIL stall_hold_cycles: got %0d required 6", hold);
        else pass_cnt++;
        chk_cnt++;
        if (!stable) $display("FAIL stall_data_stable: got changing data required %h held", held);
        else pass_cnt++;
        chk_cnt++;
        if (rom_cnt - rd !== 3) $display("FAIL stall_rom_reads: got %0d required 3", rom_cnt - rd);
        else pass_cnt++;
        chk_cnt++;
        if (first_d !== 10) $display("FAIL stall_done: got %0d required 10", first_d);
        else pass_cnt++;
        chk_cnt++;
        if (cpu_hi) $display("FAIL stall_cpu_reset_reassert: got 1 required 0");
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL stall_left: got %0d required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midcopy();
        int hs = 0, first_d = -1;
        rom_base = 32'h5500; exp_len = 11'd6;
        push_exp(6, 15'h0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            start = (k == 0); len = 11'd6;
            @(negedge clk);
            if (sram_valid && sram_ready) hs++;
            @(posedge clk); #1;
            if (hs == 2) break;
        end
        start = 1'b0;
        chk_cnt++;
        if (hs !== 2) $display("FAIL midreset_reach: got %0d handshakes required 2", hs);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({sram_valid, rom_en, busy, cpu_reset} !== 4'b0001)
            $display("FAIL midreset_async: got %b required 0001", {sram_valid, rom_en, busy, cpu_reset});
        else pass_cnt++;
        chk_cnt++;
        if ({sram_addr, sram_wdata} !== '0)
            $display("FAIL midreset_data: got %h/%h required 0/0", sram_addr, sram_wdata);
        else pass_cnt++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rom_base = 32'h6600; exp_len = 11'd2;
        push_exp(2, 15'h0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            start = (k == 0); len = 11'd2;
            @(negedge clk);
            if (k == 0) begin
                chk_cnt++;
                if (cpu_reset !== 1'b1) $display("FAIL midreset_cpu_held: got %b required 1", cpu_reset);
                else pass_cnt++;
            end
            if (done && first_d < 0) begin
                first_d = k;
                chk_cnt++;
                if (cpu_reset !== 1'b0) $display("FAIL midreset_cpu_release: got %b required 0", cpu_reset);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk_cnt++;
        if (first_d !== 4) $display("FAIL midreset_done: got %0d required 4", first_d);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL midreset_left: got %0d required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        int dn = 0, first_d = -1, vld = 0, ren = 0;
        rst = 1'b0; exp_len = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            start = (k == 0); len = '0;
            @(negedge clk);
            if (done) begin dn++; if (first_d < 0) first_d = k; end
            if (sram_valid) vld++;
            if (rom_en) ren++;
            if (k == 0) begin
                chk_cnt++;
                if (cpu_reset !== 1'b1) $display("FAIL zero_cpu_before: got %b required 1", cpu_reset);
                else pass_cnt++;
            end
            if (k == 1) begin
                chk_cnt++;
                if (cpu_reset !== 1'b0) $display("FAIL zero_cpu_after: got %b required 0", cpu_reset);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk_cnt++;
        if (first_d !== 1 || dn !== 1) $display("FAIL zero_done: got cycle %0d count %0d required 1/1", first_d, dn);
        else pass_cnt++;
        chk_cnt++;
        if (vld + ren !== 0) $display("FAIL zero_no_traffic: got %0d active cycles required 0", vld + ren);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int first_d = -1;
        rom_base = 32'h0BAD_0000;
        push_exp(4, 15'h7FF8, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            start_b = (k == 0); len_b = 11'd4;
            @(negedge clk);
            if (done_b && first_d < 0) first_d = k;
            @(posedge clk); #1;
        end
        start_b = 1'b0;
        chk_cnt++;
        if (first_d !== 6) $display("FAIL wrap_done: got %0d required 6", first_d);
        else pass_cnt++;
        chk_cnt++;
        if (exp_qb.size() !== 0) $display("FAIL wrap_left: got %0d required 0", exp_qb.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart_ignored();
        test_stall();
        test_reset_midcopy();
        test_zero_len();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
